// File: rtl/con_pattern_gen.sv
// Steppable constant/pattern source: load, rotate left/right or count up at a prescaled rate.
// Latency: con/tick/wrap update on the edge where the load or step condition is true.
// No backpressure: en gates the prescaler, and load overrides any step due that cycle.
module con_pattern_gen #(
    parameter int               WIDTH    = 8,
    parameter logic [WIDTH-1:0] INIT     = 8'b01000000,
    parameter int               PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] con,
    output logic             tick,
    output logic             wrap
);

    // Prescaler needs at least one bit even when PRESCALE is 1.
    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PCNT_LAST = PW'(PRESCALE - 1);

    localparam logic [1:0] MODE_HOLD = 2'b00;
    localparam logic [1:0] MODE_ROTL = 2'b01;
    localparam logic [1:0] MODE_ROTR = 2'b10;
    localparam logic [1:0] MODE_CNT  = 2'b11;

    logic [WIDTH-1:0] con_q, con_d;
    logic             tick_q, tick_d;
    logic             wrap_q, wrap_d;
    logic [PW-1:0]    pcnt_q, pcnt_d;
    logic             step_due;

    // Next-state: load beats step; the prescaler only moves while enabled and not holding.
    always_comb begin
        con_d    = con_q;
        tick_d   = 1'b0;
        wrap_d   = 1'b0;
        pcnt_d   = pcnt_q;
        step_due = 1'b0;

        if (en && (mode != MODE_HOLD)) begin
            if (pcnt_q == PCNT_LAST) begin
                step_due = 1'b1;
                pcnt_d   = '0;
            end else begin
                pcnt_d   = pcnt_q + 1'b1;
            end
        end

        if (load) begin
            // A step falling on the load cycle is dropped and the prescale period restarts.
            con_d  = load_val;
            pcnt_d = '0;
        end else if (step_due) begin
            tick_d = 1'b1;
            unique case (mode)
                MODE_ROTL: begin
                    con_d  = {con_q[WIDTH-2:0], con_q[WIDTH-1]};
                    wrap_d = con_q[WIDTH-1];
                end
                MODE_ROTR: begin
                    con_d  = {con_q[0], con_q[WIDTH-1:1]};
                    wrap_d = con_q[0];
                end
                MODE_CNT: begin
                    con_d  = con_q + 1'b1;
                    wrap_d = &con_q;
                end
                default: begin
                    con_d  = con_q;
                    tick_d = 1'b0;
                end
            endcase
        end
    end

    // State registers with synchronous reset taking priority over everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            con_q  <= INIT;
            tick_q <= 1'b0;
            wrap_q <= 1'b0;
            pcnt_q <= '0;
        end else begin
            con_q  <= con_d;
            tick_q <= tick_d;
            wrap_q <= wrap_d;
            pcnt_q <= pcnt_d;
        end
    end

    assign con  = con_q;
    assign tick = tick_q;
    assign wrap = wrap_q;

endmodule
